idli_sqi_ctrl_m: RTL

// SQI memory controller: sequences one 16b read or write transaction per request
// (command, address, dummy, data phases) on the quad SIO pins. Sits upstream of the

---
 rtl/idli_sqi_ctrl_m.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/idli_sqi_ctrl_m.sv
// SQI memory controller: EQIO mode switch after reset, then one 16b read or write
// transaction per request (command, address, dummy, data) on the quad SIO pins.
module idli_sqi_ctrl_m #(
   parameter logic [7:0]  CMD_READ  = 8'h03,
   parameter logic [7:0]  CMD_WRITE = 8'h02,
   parameter logic [7:0]  CMD_EQIO  = 8'h38,
   parameter int unsigned DUMMY_NIB = 2
) (
   input  logic        i_sqi_gck,
   input  logic        i_sqi_rst,
   input  logic        i_sqi_req,
   input  logic        i_sqi_wr,
   input  logic [15:0] i_sqi_addr,
   output logic        o_sqi_ack,
   output logic        o_sqi_busy,
   output logic        o_sqi_done,
   output logic        o_sqi_cs,
   output logic        o_sqi_sio_oe,
   output logic [3:0]  o_sqi_sio,
   input  logic [3:0]  i_sqi_sio,
   output logic        o_sqi_reg_wr_en,
   input  logic [3:0]  i_sqi_reg_data
);

   localparam int unsigned CNT_W = 3;
   localparam logic [CNT_W-1:0] DUMMY_LAST = CNT_W'(DUMMY_NIB - 1);

   typedef enum logic [2:0] {
      ST_INIT, ST_INIT_END, ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA, ST_END
   } state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic               wr_q, wr_nxt;
   logic [15:0]        addr_q, addr_nxt;
   logic [7:0]         instr;
   logic               unused_sio;

   // Read nibbles go straight from the pins into the IO register, not through here.
   assign unused_sio = ^i_sqi_sio;
   assign instr      = wr_q ? CMD_WRITE : CMD_READ;

   always_ff @(posedge i_sqi_gck or posedge i_sqi_rst) begin
      if (i_sqi_rst) begin
         state  <= ST_INIT;
         cnt    <= '0;
         wr_q   <= 1'b0;
         addr_q <= '0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         wr_q   <= wr_nxt;
         addr_q <= addr_nxt;
      end
   end

   // Next state; the nibble counter restarts on every phase change.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + CNT_W'(1);
      wr_nxt    = wr_q;
      addr_nxt  = addr_q;
      case (state)
         ST_INIT:     if (cnt == 3'd7) state_nxt = ST_INIT_END;
         ST_INIT_END: state_nxt = ST_IDLE;
         ST_IDLE: begin
            cnt_nxt = '0;
            if (i_sqi_req) begin
               state_nxt = ST_CMD;
               wr_nxt    = i_sqi_wr;
               addr_nxt  = i_sqi_addr;
            end
         end
         ST_CMD:      if (cnt == 3'd1) state_nxt = ST_ADDR;
         ST_ADDR:     if (cnt == 3'd3) state_nxt = wr_q ? ST_DATA : ST_DUMMY;
         ST_DUMMY:    if (cnt == DUMMY_LAST) state_nxt = ST_DATA;
         ST_DATA:     if (cnt == 3'd3) state_nxt = ST_END;
         ST_END:      state_nxt = ST_IDLE;
         default:     state_nxt = ST_INIT;
      endcase
      if (state_nxt != state) cnt_nxt = '0;
   end

   // Pin and handshake decode; reset forces the idle pin state immediately.
   always_comb begin
      o_sqi_cs        = 1'b1;
      o_sqi_sio_oe    = 1'b0;
      o_sqi_sio       = 4'h0;
      o_sqi_ack       = 1'b0;
      o_sqi_done      = 1'b0;
      o_sqi_reg_wr_en = 1'b0;
      o_sqi_busy      = 1'b1;
      case (state)
         ST_INIT: begin
            o_sqi_cs     = 1'b0;
            o_sqi_sio_oe = 1'b1;
            o_sqi_sio    = {3'b000, CMD_EQIO[3'd7 - cnt]};
         end
         ST_IDLE: begin
            o_sqi_busy = 1'b0;
            o_sqi_ack  = i_sqi_req;
         end
         ST_CMD: begin
            o_sqi_cs     = 1'b0;
            o_sqi_sio_oe = 1'b1;
            o_sqi_sio    = cnt[0] ? instr[3:0] : instr[7:4];
         end
         ST_ADDR: begin
            o_sqi_cs     = 1'b0;
            o_sqi_sio_oe = 1'b1;
            case (cnt[1:0])
               2'd0:    o_sqi_sio = addr_q[15:12];
               2'd1:    o_sqi_sio = addr_q[11:8];
               2'd2:    o_sqi_sio = addr_q[7:4];
               default: o_sqi_sio = addr_q[3:0];
            endcase
         end
         ST_DUMMY: o_sqi_cs = 1'b0;
         ST_DATA: begin
            o_sqi_cs = 1'b0;
            if (wr_q) begin
               o_sqi_sio_oe = 1'b1;
               o_sqi_sio    = i_sqi_reg_data;
            end else begin
               o_sqi_reg_wr_en = 1'b1;
            end
         end
         ST_END:  o_sqi_done = 1'b1;
         default: ;
      endcase
      if (i_sqi_rst) begin
         o_sqi_cs        = 1'b1;
         o_sqi_sio_oe    = 1'b0;
         o_sqi_sio       = 4'h0;
         o_sqi_ack       = 1'b0;
         o_sqi_done      = 1'b0;
         o_sqi_reg_wr_en = 1'b0;
         o_sqi_busy      = 1'b1;
      end
   end

endmodule
